// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  // Pipeline control bundle produced each cycle.
  typedef struct packed {
    logic muldiv_start;
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard controller bus: pipeline/MUL-DIV status in, stall/flush/counter out.
interface hazard_controller_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  import hazard_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_branch_taken;
  logic                  ex_muldiv_valid;
  logic                  muldiv_done;

  logic                  muldiv_start;
  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  id_ex_stall;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic [CNT_WIDTH-1:0]  perf_load_use;
  logic [CNT_WIDTH-1:0]  perf_muldiv_stall;
  logic [CNT_WIDTH-1:0]  perf_branch_flush;

  // Pipeline / MUL-DIV side
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd_addr, ex_branch_taken, ex_muldiv_valid, muldiv_done,
    input  muldiv_start, pc_stall, if_id_stall, id_ex_stall,
           if_id_flush, id_ex_flush, ex_mem_flush,
           perf_load_use, perf_muldiv_stall, perf_branch_flush
  );

  // Hazard controller side
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd_addr, ex_branch_taken, ex_muldiv_valid, muldiv_done,
    output muldiv_start, pc_stall, if_id_stall, id_ex_stall,
           if_id_flush, id_ex_flush, ex_mem_flush,
           perf_load_use, perf_muldiv_stall, perf_branch_flush
  );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with async clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Load-use bubbles, taken-branch flushes and MUL/DIV freeze sequencing.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  md_state_e    state_q;
  hazard_ctrl_t ctrl;
  logic         load_use_c;
  logic         start_c;
  logic         freeze_c;
  logic         branch_c;
  logic         lu_bubble_c;

  // Hazard detection and priority: MUL/DIV freeze > branch > load-use.
  // Outputs are forced low while rst is held so reset takes effect at once.
  always_comb begin
    load_use_c  = hz.ex_mem_read && (hz.ex_rd_addr != REG_ZERO) &&
                  ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                   (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));
    start_c     = !rst && (state_q == MD_IDLE) && hz.ex_muldiv_valid;
    freeze_c    = start_c || (!rst && (state_q == MD_WAIT) && !hz.muldiv_done);
    branch_c    = !rst && !freeze_c && hz.ex_branch_taken;
    lu_bubble_c = !rst && !freeze_c && !hz.ex_branch_taken && load_use_c;

    ctrl              = '0;
    ctrl.muldiv_start = start_c;
    ctrl.pc_stall     = freeze_c || lu_bubble_c;
    ctrl.if_id_stall  = freeze_c || lu_bubble_c;
    ctrl.id_ex_stall  = freeze_c;
    ctrl.ex_mem_flush = freeze_c;
    ctrl.if_id_flush  = branch_c;
    ctrl.id_ex_flush  = branch_c || lu_bubble_c;
  end

  // MUL/DIV handshake state; done only matters while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (hz.ex_muldiv_valid) state_q <= MD_WAIT;
        MD_WAIT: if (hz.muldiv_done)     state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign hz.muldiv_start = ctrl.muldiv_start;
  assign hz.pc_stall     = ctrl.pc_stall;
  assign hz.if_id_stall  = ctrl.if_id_stall;
  assign hz.id_ex_stall  = ctrl.id_ex_stall;
  assign hz.if_id_flush  = ctrl.if_id_flush;
  assign hz.id_ex_flush  = ctrl.id_ex_flush;
  assign hz.ex_mem_flush = ctrl.ex_mem_flush;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_load_use (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu_bubble_c),
    .count (hz.perf_load_use)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_muldiv_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_c),
    .count (hz.perf_muldiv_stall)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_branch_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_c),
    .count (hz.perf_branch_flush)
  );
`else
  assign hz.perf_load_use     = CNT_WIDTH'(0);
  assign hz.perf_muldiv_stall = CNT_WIDTH'(0);
  assign hz.perf_branch_flush = CNT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a 32-bit-counter instance plus a
// 2-bit-counter instance fed the same stimulus to exercise saturation.
module tb_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_controller_if #(.CNT_WIDTH(32)) hz ();
  hazard_controller_if #(.CNT_WIDTH(2))  hz2 ();

  hazard_controller #(.CNT_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  hazard_controller #(.CNT_WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .hz  (hz2)
  );

  assign hz2.id_rs1_addr     = hz.id_rs1_addr;
  assign hz2.id_rs2_addr     = hz.id_rs2_addr;
  assign hz2.id_uses_rs1     = hz.id_uses_rs1;
  assign hz2.id_uses_rs2     = hz.id_uses_rs2;
  assign hz2.ex_mem_read     = hz.ex_mem_read;
  assign hz2.ex_rd_addr      = hz.ex_rd_addr;
  assign hz2.ex_branch_taken = hz.ex_branch_taken;
  assign hz2.ex_muldiv_valid = hz.ex_muldiv_valid;
  assign hz2.muldiv_done     = hz.muldiv_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {start, pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush}
  logic [6:0] ctrl_v;
  assign ctrl_v = {hz.muldiv_start, hz.pc_stall, hz.if_id_stall, hz.id_ex_stall,
                   hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush};

  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_START  = 7'b1111001;
  localparam logic [6:0] C_FREEZE = 7'b0111001;
  localparam logic [6:0] C_LU     = 7'b0110010;
  localparam logic [6:0] C_BR     = 7'b0000110;

  function automatic logic [31:0] ecnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mr,
                        input logic [4:0] rd, input logic br,
                        input logic mv, input logic done);
    hz.id_rs1_addr     = rs1;
    hz.id_rs2_addr     = rs2;
    hz.id_uses_rs1     = u1;
    hz.id_uses_rs2     = u2;
    hz.ex_mem_read     = mr;
    hz.ex_rd_addr      = rd;
    hz.ex_branch_taken = br;
    hz.ex_muldiv_valid = mv;
    hz.muldiv_done     = done;
  endtask

  // Drive at the falling edge, sample 1 ns later.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr,
                      input logic [4:0] rd, input logic br,
                      input logic mv, input logic done);
    @(negedge clk);
    set_in(rs1, rs2, u1, u2, mr, rd, br, mv, done);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("reset_ctrl", 32'(ctrl_v), 32'(C_IDLE));
    chk("reset_lu_cnt", hz.perf_load_use, 32'd0);
    chk("reset_md_cnt", hz.perf_muldiv_stall, 32'd0);
    chk("reset_br_cnt", hz.perf_branch_flush, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Load-use on rs1, then load moves on
    step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_rs1", 32'(ctrl_v), 32'(C_LU));
    step(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_one_cycle", 32'(ctrl_v), 32'(C_IDLE));
    chk("lu_cnt_1", hz.perf_load_use, ecnt(1));

    // x0 never hazards; rs2 match; rs2 match without use
    step(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("x0_no_hazard", 32'(ctrl_v), 32'(C_IDLE));
    step(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("lu_rs2", 32'(ctrl_v), 32'(C_LU));
    step(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("rs2_unused", 32'(ctrl_v), 32'(C_IDLE));

    // Branch beats simultaneous load-use
    step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("branch_over_lu", 32'(ctrl_v), 32'(C_BR));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("after_branch", 32'(ctrl_v), 32'(C_IDLE));
    chk("lu_cnt_2", hz.perf_load_use, ecnt(2));
    chk("br_cnt_1", hz.perf_branch_flush, ecnt(1));

    // MUL with done 4 cycles after start
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("md_start", 32'(ctrl_v), 32'(C_START));
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("md_wait_%0d", i), 32'(ctrl_v), 32'(C_FREEZE));
    end
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("md_done_adv", 32'(ctrl_v), 32'(C_IDLE));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("md_after", 32'(ctrl_v), 32'(C_IDLE));
    chk("md_cnt_4", hz.perf_muldiv_stall, ecnt(4));

    // Done ignored in idle, then back-to-back MUL/DIV (L=1, then L=2)
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("idle_done_ign", 32'(ctrl_v), 32'(C_IDLE));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("start_with_done", 32'(ctrl_v), 32'(C_START));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("b2b_first_done", 32'(ctrl_v), 32'(C_IDLE));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("b2b_second_start", 32'(ctrl_v), 32'(C_START));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("b2b_second_wait", 32'(ctrl_v), 32'(C_FREEZE));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("b2b_second_done", 32'(ctrl_v), 32'(C_IDLE));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("md_cnt_7", hz.perf_muldiv_stall, ecnt(7));

    // Async reset two cycles into a MUL/DIV
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_md_start", 32'(ctrl_v), 32'(C_START));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_md_wait", 32'(ctrl_v), 32'(C_FREEZE));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 32'(ctrl_v), 32'(C_IDLE));
    chk("rst_async_md_cnt", hz.perf_muldiv_stall, 32'd0);
    chk("rst_async_lu_cnt", hz.perf_load_use, 32'd0);
    chk("rst_async_br_cnt", hz.perf_branch_flush, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("post_rst_done_ign", 32'(ctrl_v), 32'(C_IDLE));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_idle", 32'(ctrl_v), 32'(C_START));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("post_rst_done", 32'(ctrl_v), 32'(C_IDLE));

    // Five taken branches: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("branch_%0d", i), 32'(ctrl_v), 32'(C_BR));
    end
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("br_cnt_5", hz.perf_branch_flush, ecnt(5));
    chk("br_cnt_sat", 32'(hz2.perf_branch_flush), PERF ? 32'd3 : 32'd0);
    chk("md_cnt_post_rst", hz.perf_muldiv_stall, ecnt(1));
    chk("md_cnt2_post_rst", 32'(hz2.perf_muldiv_stall), ecnt(1));
    chk("lu_cnt_post_rst", hz.perf_load_use, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
